// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer between uart_rx and the command decoder: buffers one frame,
// validates length/XOR checksum, then replays it on a valid/ready byte stream.
module uart_rx_frame_ctrl #(
  parameter int MAX_LEN   = 64,
  parameter int LEN_W     = 7,
  parameter int CHECK_XOR = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_eop,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_drop,
  output logic [7:0]       drop_cnt
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_SEND,
    ST_DISCARD
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rd_q, rd_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [7:0]       xor_q, xor_d;
  logic             foreign_q, foreign_d;
  logic             frame_drop_q, frame_drop_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [7:0]       rdata_q;

  logic [7:0]       mem [MAX_LEN];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [LEN_W-1:0] rd_inc;
  logic [1:0]       drop_n;
  logic [8:0]       drop_sum;
  logic             check_ok;
  logic             foreign_now;
  logic             is_last;

  assign out_valid  = (state_q == ST_SEND);
  assign is_last    = (rd_q == frame_len_q - LEN_ONE);
  assign out_last   = out_valid & is_last;
  assign out_data   = rdata_q;
  assign frame_len  = frame_len_q;
  assign frame_drop = frame_drop_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_d        = rd_q;
    frame_len_d = frame_len_q;
    xor_d       = xor_q;
    foreign_d   = foreign_q;
    wr_en       = 1'b0;
    wr_addr     = len_q[AW-1:0];
    rd_en       = 1'b0;
    rd_inc      = rd_q + LEN_ONE;
    rd_addr     = rd_inc[AW-1:0];
    drop_n      = 2'd0;
    foreign_now = foreign_q | rx_ready;
    if (CHECK_XOR != 0) begin
      check_ok = (len_q >= LEN_TWO) && (xor_q == 8'h00);
    end else begin
      check_ok = (len_q >= LEN_ONE);
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = LEN_ONE;
          xor_d   = rx_data;
          state_d = rx_eop ? ST_CHECK : ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_ready && (len_q >= LEN_MAX)) begin
          // Overflow: an end marker in the same cycle closes the frame right away.
          if (rx_eop) begin
            drop_n  = 2'd1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end else begin
          if (rx_ready) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_ONE;
            xor_d = xor_q ^ rx_data;
          end
          if (rx_eop) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (rx_eop && foreign_now) begin
          drop_n    = drop_n + 2'd1;
          foreign_d = 1'b0;
        end else if (rx_ready) begin
          foreign_d = 1'b1;
        end
        if (check_ok) begin
          rd_en       = 1'b1;
          rd_addr     = '0;
          rd_d        = '0;
          frame_len_d = len_q;
          state_d     = ST_SEND;
        end else begin
          drop_n  = drop_n + 2'd1;
          // A foreign frame still in flight must not be picked up mid-stream.
          state_d = foreign_d ? ST_DISCARD : ST_IDLE;
        end
      end
      ST_SEND: begin
        if (rx_eop && foreign_now) begin
          drop_n    = 2'd1;
          foreign_d = 1'b0;
        end else if (rx_ready) begin
          foreign_d = 1'b1;
        end
        if (out_ready) begin
          if (is_last) begin
            state_d = foreign_d ? ST_DISCARD : ST_IDLE;
          end else begin
            rd_d  = rd_inc;
            rd_en = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (rx_eop) begin
          drop_n    = 2'd1;
          foreign_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    drop_sum     = {1'b0, drop_cnt_q} + {7'd0, drop_n};
    drop_cnt_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    frame_drop_d = (drop_n != 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_q <= 8'h00;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      rd_q         <= '0;
      frame_len_q  <= '0;
      xor_q        <= 8'h00;
      foreign_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      drop_cnt_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_q         <= rd_d;
      frame_len_q  <= frame_len_d;
      xor_q        <= xor_d;
      foreign_q    <= foreign_d;
      frame_drop_q <= frame_drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: table vectors, directed corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_rx_frame_ctrl;
  localparam int MAX_LEN   = 64;
  localparam int LEN_W     = 7;
  localparam int CHECK_XOR = 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             rx_ready = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_eop = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic [LEN_W-1:0] frame_len;
  logic             frame_drop;
  logic [7:0]       drop_cnt;

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CHECK_XOR(CHECK_XOR)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_ready(rx_ready), .rx_data(rx_data), .rx_eop(rx_eop),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frame_len(frame_len), .frame_drop(frame_drop), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]       data;
    logic             last;
    logic [LEN_W-1:0] len;
  } beat_t;

  typedef struct {
    logic [31:0] bytes;
    int          n;
    bit          eop_same;
    bit          deliver;
    int          drops;
  } vec_t;

  beat_t            exp_q[$];
  logic [7:0]       fb[$];
  vec_t             vt[9];
  int               tests = 0;
  int               fails = 0;
  int               exp_drops = 0;
  int               obs_pulses = 0;
  bit               rand_rdy = 1'b0;
  bit               stall_prev = 1'b0;
  logic [7:0]       held_data;
  logic             held_last;
  logic [LEN_W-1:0] held_len;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (!RST_N) begin
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev && out_valid)
      check("stall_hold", {out_data, out_last, frame_len}, {held_data, held_last, held_len});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %0h, expected no transfer", out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat", {out_data, out_last, frame_len}, {e.data, e.last, e.len});
      end
    end
    if (frame_drop) obs_pulses++;
    stall_prev = out_valid && !out_ready;
    held_data  = out_data;
    held_last  = out_last;
    held_len   = frame_len;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_fb(input bit eop_same, input int gap);
    for (int i = 0; i < fb.size(); i++) begin
      rx_ready = 1'b1;
      rx_data  = fb[i];
      rx_eop   = eop_same && (i == fb.size() - 1);
      tick();
      rx_ready = 1'b0;
      rx_eop   = 1'b0;
      repeat (gap) tick();
    end
    if (!eop_same) begin
      rx_eop = 1'b1;
      tick();
      rx_eop = 1'b0;
    end
  endtask

  // Reference rule: accepted iff it fits the buffer and passes the length/XOR test.
  function automatic bit frame_ok();
    logic [7:0] x = 8'h00;
    if (fb.size() > MAX_LEN) return 1'b0;
    foreach (fb[i]) x ^= fb[i];
    if (CHECK_XOR != 0) return (fb.size() >= 2) && (x == 8'h00);
    return fb.size() >= 1;
  endfunction

  task automatic push_expect();
    beat_t b;
    for (int i = 0; i < fb.size(); i++) begin
      b.data = fb[i];
      b.last = (i == fb.size() - 1);
      b.len  = LEN_W'(fb.size());
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 2000) begin
      tick();
      k++;
    end
    check({nm, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    check(nm, out_valid, 1);
  endtask

  task automatic check_drops(input string nm);
    check({nm, "_cnt"}, drop_cnt, (exp_drops > 255) ? 255 : exp_drops);
    check({nm, "_pulses"}, obs_pulses, exp_drops);
  endtask

  task automatic fill_seq(input int n, input bit fix_sum);
    logic [7:0] x = 8'h00;
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'(i + 1));
    if (fix_sum) begin
      for (int i = 0; i < n - 1; i++) x ^= fb[i];
      fb[n-1] = x;
    end
  endtask

  initial begin
    vt[0] = '{bytes: 32'h48652D00, n: 3, eop_same: 1'b0, deliver: 1'b1, drops: 0};
    vt[1] = '{bytes: 32'h48650000, n: 3, eop_same: 1'b0, deliver: 1'b0, drops: 1};
    vt[2] = '{bytes: 32'h00000000, n: 1, eop_same: 1'b0, deliver: 1'b0, drops: 2};
    vt[3] = '{bytes: 32'h48652D00, n: 3, eop_same: 1'b1, deliver: 1'b1, drops: 2};
    vt[4] = '{bytes: 32'h01010000, n: 2, eop_same: 1'b1, deliver: 1'b1, drops: 2};
    vt[5] = '{bytes: 32'h00000000, n: 2, eop_same: 1'b0, deliver: 1'b1, drops: 2};
    vt[6] = '{bytes: 32'h12345670, n: 4, eop_same: 1'b0, deliver: 1'b1, drops: 2};
    vt[7] = '{bytes: 32'hFF000000, n: 1, eop_same: 1'b0, deliver: 1'b0, drops: 3};
    vt[8] = '{bytes: 32'hABCD0000, n: 2, eop_same: 1'b1, deliver: 1'b0, drops: 4};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_len", frame_len, 0);
    check("rst_drop", frame_drop, 0);
    check("rst_cnt", drop_cnt, 0);
    RST_N = 1'b1;
    out_ready = 1'b1;
    tick();

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      fb.delete();
      for (int i = 0; i < vt[v].n; i++) fb.push_back(vt[v].bytes[31-8*i -: 8]);
      if (vt[v].deliver) push_expect();
      else exp_drops++;
      send_fb(vt[v].eop_same, 1);
      repeat (3) tick();
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_drops", v), drop_cnt, vt[v].drops);
      check($sformatf("vec%0d_pulses", v), obs_pulses, vt[v].drops);
      $display("[TB] vec%0d n=%0d deliver=%0b drop_cnt=%0d", v, vt[v].n, vt[v].deliver, drop_cnt);
    end

    // Overflow, then a good frame with latency check
    fill_seq(65, 1'b0);
    exp_drops++;
    send_fb(1'b0, 0);
    repeat (3) tick();
    check_drops("ovf65");
    fb = '{8'h01, 8'h01};
    push_expect();
    send_fb(1'b0, 0);
    check("lat_c1", out_valid, 0);
    tick();
    check("lat_c2", out_valid, 1);
    wait_drain("after_ovf");
    $display("[TB] overflow frame dropped, 2-byte frame delivered");

    fill_seq(65, 1'b0);
    exp_drops++;
    send_fb(1'b1, 0);
    repeat (3) tick();
    check_drops("ovf65_same");
    check("ovf65_same_novalid", out_valid, 0);
    fill_seq(64, 1'b1);
    push_expect();
    send_fb(1'b0, 0);
    repeat (3) tick();
    wait_drain("max64");
    $display("[TB] 65-byte same-cycle eop dropped, 64-byte frame delivered");

    // Foreign frame arriving while the first one is stalled
    out_ready = 1'b0;
    fb = '{8'h48, 8'h65, 8'h2D};
    push_expect();
    send_fb(1'b0, 1);
    wait_valid("t4_valid");
    fb = '{8'hAA, 8'hAA};
    exp_drops++;
    send_fb(1'b0, 1);
    repeat (3) tick();
    check_drops("t4");
    check("t4_hold_data", out_data, 8'h48);
    out_ready = 1'b1;
    wait_drain("t4_first");
    $display("[TB] stalled frame delivered, foreign frame dropped");

    // Foreign bytes still open when SEND ends
    out_ready = 1'b0;
    fb = '{8'h48, 8'h65, 8'h2D};
    push_expect();
    send_fb(1'b0, 1);
    wait_valid("t4b_valid");
    rx_ready = 1'b1;
    rx_data  = 8'hAA;
    tick();
    rx_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain("t4b_first");
    rx_ready = 1'b1;
    rx_data  = 8'hAB;
    tick();
    rx_ready = 1'b0;
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    exp_drops++;
    repeat (3) tick();
    check_drops("t4b");
    fb = '{8'h01, 8'h01};
    push_expect();
    send_fb(1'b0, 0);
    repeat (3) tick();
    wait_drain("t4b_next");
    $display("[TB] partial foreign frame discarded, next frame delivered");

    // Reset in the middle of SEND
    out_ready = 1'b0;
    fb = '{8'h48, 8'h65, 8'h2D};
    push_expect();
    send_fb(1'b0, 0);
    wait_valid("t6_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_sent_one", exp_q.size(), 2);
    #2 RST_N = 1'b0;
    #1;
    check("t6_valid0", out_valid, 0);
    check("t6_last0", out_last, 0);
    check("t6_data0", out_data, 0);
    check("t6_len0", frame_len, 0);
    check("t6_cnt0", drop_cnt, 0);
    exp_q.delete();
    exp_drops  = 0;
    obs_pulses = 0;
    tick();
    RST_N = 1'b1;
    out_ready = 1'b1;
    tick();
    fb = '{8'h48, 8'h65, 8'h2D};
    push_expect();
    send_fb(1'b0, 0);
    repeat (3) tick();
    wait_drain("t6_after");
    check_drops("t6");
    $display("[TB] reset mid-SEND, next frame delivered from byte 0");

    // Randomized frames against the model
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int  r;
      int  n;
      bit  same;
      logic [7:0] x;
      r = $urandom_range(0, 9);
      if (r < 7) n = $urandom_range(2, 12);
      else if (r < 8) n = 1;
      else n = $urandom_range(60, 68);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        x = 8'h00;
        for (int i = 0; i < n - 1; i++) x ^= fb[i];
        fb[n-1] = x;
      end
      same = (n > 1) && ($urandom_range(0, 2) == 0);
      if (frame_ok()) push_expect();
      else exp_drops++;
      $display("[TB] rand%0d n=%0d eop_same=%0b accept=%0b", k, n, same, frame_ok());
      send_fb(same, $urandom_range(0, 2));
      repeat (3) tick();
      wait_drain($sformatf("rand%0d", k));
      repeat (2) tick();
      check_drops($sformatf("rand%0d", k));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

    // Drop counter saturation
    for (int k = 0; k < 260; k++) begin
      fb = '{8'h00};
      exp_drops++;
      send_fb(1'b0, 0);
      repeat (2) tick();
    end
    repeat (3) tick();
    check_drops("sat");
    $display("[TB] saturation: drop_cnt=%0d pulses=%0d", drop_cnt, obs_pulses);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
